// File: rtl/sel_pkg.sv
// Shared encodings for the scanning one-hot path selector.
package sel_pkg;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'b00,
    MODE_DIRECT    = 2'b01,
    MODE_SCAN_UP   = 2'b10,
    MODE_SCAN_DOWN = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sel_decoder_scan_chk.sv
// Invariant checker: path is zero or one-hot, and when set it matches cur_sel.
module sel_decoder_scan_chk #(
  parameter int SEL_W = 4
) (
  input logic                  clk1,
  input logic [(2**SEL_W)-1:0] path,
  input logic [SEL_W-1:0]      cur_sel
);

  localparam int OUT_W = 2**SEL_W;

  logic [OUT_W-1:0] expect_hot_s;

  sel_onehot #(.SEL_W(SEL_W)) u_dec (
    .idx    (cur_sel),
    .onehot (expect_hot_s)
  );

  // outputs are stable away from the rising edge
  always @(negedge clk1) begin
    assert ($onehot0(path)) else $error("FAIL chk_onehot path=%h", path);
    assert ((path == '0) || (path == expect_hot_s))
      else $error("FAIL chk_match path=%h cur_sel=%0d", path, cur_sel);
  end

endmodule

// File: rtl/sel_onehot.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder: bit i is set when idx == i.
module sel_onehot #(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [(2**SEL_W)-1:0] onehot
);

  localparam int OUT_W = 2**SEL_W;

  // decode one output bit per possible index value
  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (idx == SEL_W'(i)) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sel_decoder_scan.sv
// Registered one-hot path selector with direct selection and an up/down
// auto-scan mode holding each path for a programmable number of cycles.
module sel_decoder_scan
  import sel_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      select,
  input  logic                  load,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] path,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  wrap,
  output logic                  busy
);

  localparam int OUT_W = 2**SEL_W;

  state_e             state_r,     state_s;
  logic [OUT_W-1:0]   path_r,      path_s;
  logic [SEL_W-1:0]   cur_sel_r,   cur_sel_s;
  logic               wrap_r,      wrap_s;
  logic               busy_r,      busy_s;
  logic [DWELL_W-1:0] dwell_cnt_r, dwell_cnt_s;
  logic [DWELL_W-1:0] dwell_reg_r, dwell_reg_s;

  logic [DWELL_W-1:0] dwell_eff_s;
  logic [SEL_W-1:0]   step_sel_s;
  logic               step_wrap_s;
  logic [OUT_W-1:0]   select_hot_s;
  logic [OUT_W-1:0]   step_hot_s;

  sel_onehot #(.SEL_W(SEL_W)) u_dec_select (
    .idx    (select),
    .onehot (select_hot_s)
  );

  sel_onehot #(.SEL_W(SEL_W)) u_dec_step (
    .idx    (step_sel_s),
    .onehot (step_hot_s)
  );

  // next scan index and end-crossing detect for the current direction
  always_comb begin
    dwell_eff_s = (dwell == '0) ? DWELL_W'(1) : dwell;
    if (mode == MODE_SCAN_DOWN) begin
      step_sel_s  = cur_sel_r - SEL_W'(1);
      step_wrap_s = (cur_sel_r == '0);
    end else begin
      step_sel_s  = cur_sel_r + SEL_W'(1);
      step_wrap_s = (cur_sel_r == '1);
    end
  end

  // next-state and output decision; en low holds everything except wrap
  always_comb begin
    state_s     = state_r;
    path_s      = path_r;
    cur_sel_s   = cur_sel_r;
    wrap_s      = 1'b0;
    busy_s      = busy_r;
    dwell_cnt_s = dwell_cnt_r;
    dwell_reg_s = dwell_reg_r;

    if (en) begin
      case (mode)
        MODE_OFF: begin
          state_s = ST_IDLE;
          path_s  = '0;
          busy_s  = 1'b0;
        end
        MODE_DIRECT: begin
          state_s   = ST_IDLE;
          cur_sel_s = select;
          path_s    = select_hot_s;
          busy_s    = 1'b0;
        end
        MODE_SCAN_UP, MODE_SCAN_DOWN: begin
          if (load) begin
            // a load always wins over a coincident step, so never wraps
            state_s     = ST_RUN;
            cur_sel_s   = select;
            path_s      = select_hot_s;
            busy_s      = 1'b1;
            dwell_reg_s = dwell_eff_s;
            dwell_cnt_s = dwell_eff_s - DWELL_W'(1);
          end else if (state_r == ST_RUN) begin
            busy_s = 1'b1;
            if (dwell_cnt_r != '0) begin
              dwell_cnt_s = dwell_cnt_r - DWELL_W'(1);
            end else begin
              cur_sel_s   = step_sel_s;
              path_s      = step_hot_s;
              wrap_s      = step_wrap_s;
              dwell_cnt_s = dwell_reg_r - DWELL_W'(1);
            end
          end else begin
            path_s = '0;
            busy_s = 1'b0;
          end
        end
        default: begin
          state_s = ST_IDLE;
          path_s  = '0;
          busy_s  = 1'b0;
        end
      endcase
    end else begin
      wrap_s = 1'b0;
    end
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      path_r      <= '0;
      cur_sel_r   <= '0;
      wrap_r      <= 1'b0;
      busy_r      <= 1'b0;
      dwell_cnt_r <= '0;
      dwell_reg_r <= '0;
    end else begin
      state_r     <= state_s;
      path_r      <= path_s;
      cur_sel_r   <= cur_sel_s;
      wrap_r      <= wrap_s;
      busy_r      <= busy_s;
      dwell_cnt_r <= dwell_cnt_s;
      dwell_reg_r <= dwell_reg_s;
    end
  end

  assign path    = path_r;
  assign cur_sel = cur_sel_r;
  assign wrap    = wrap_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_sel_decoder_scan.sv
// Directed bench for sel_decoder_scan with a queue scoreboard of expected outputs.
module tb_sel_decoder_scan;
  import sel_pkg::*;

  typedef struct {
    string      tag;
    logic [15:0] path;
    logic [3:0] sel;
    logic       wrap;
    logic       busy;
  } exp_t;

  logic        clk1 = 1'b0;
  logic        rst_n, en, load;
  logic [1:0]  mode;
  logic [3:0]  select;
  logic [7:0]  dwell;
  logic [15:0] path;
  logic [3:0]  cur_sel;
  logic        wrap, busy;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  sel_decoder_scan #(.SEL_W(4), .DWELL_W(8)) dut (
    .clk1(clk1), .rst_n(rst_n), .en(en), .mode(mode), .select(select),
    .load(load), .dwell(dwell), .path(path), .cur_sel(cur_sel),
    .wrap(wrap), .busy(busy)
  );

  sel_decoder_scan_chk #(.SEL_W(4)) u_chk (
    .clk1(clk1), .path(path), .cur_sel(cur_sel)
  );

  always #5 clk1 = ~clk1;

  // drive one cycle of inputs, queue the expected result, compare after the edge
  task automatic cyc(input logic rn, input logic e, input logic [1:0] m,
                     input logic [3:0] s, input logic ld, input logic [7:0] dw,
                     input string tag, input logic on, input logic [3:0] xs,
                     input logic xw, input logic xb);
    exp_t x;
    logic [15:0] one;
    one = 16'h0001;
    rst_n = rn; en = e; mode = m; select = s; load = ld; dwell = dw;
    x.tag  = tag;
    x.path = on ? (one << xs) : 16'h0000;
    x.sel  = xs;
    x.wrap = xw;
    x.busy = xb;
    sb.push_back(x);
    @(posedge clk1);
    #1;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard empty", tag);
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      n_checks++;
      assert (path === x.path) else begin
        n_fail++;
        $error("FAIL %s path observed=%h expected=%h", x.tag, path, x.path);
      end
      n_checks++;
      assert (cur_sel === x.sel) else begin
        n_fail++;
        $error("FAIL %s cur_sel observed=%0d expected=%0d", x.tag, cur_sel, x.sel);
      end
      n_checks++;
      assert (wrap === x.wrap) else begin
        n_fail++;
        $error("FAIL %s wrap observed=%b expected=%b", x.tag, wrap, x.wrap);
      end
      n_checks++;
      assert (busy === x.busy) else begin
        n_fail++;
        $error("FAIL %s busy observed=%b expected=%b", x.tag, busy, x.busy);
      end
    end
  endtask

  initial begin
    int up_seq[9];
    rst_n = 1'b0; en = 1'b1; mode = 2'b01; select = 4'd5; load = 1'b0; dwell = 8'd0;

    // reset dominates DIRECT select=5
    cyc(1'b0, 1'b1, 2'b01, 4'd5, 1'b0, 8'd0, "reset0", 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 4'd5, 1'b1, 8'd0, "reset1", 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b01, 4'd5, 1'b0, 8'd0, "release", 1'b1, 4'd5, 1'b0, 1'b0);

    // DIRECT sweep, load has no effect
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 1'b1, 2'b01, 4'(i), 1'(i % 2), 8'd3, "direct", 1'b1, 4'(i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b00, 4'd3, 1'b0, 8'd0, "off", 1'b0, 4'd15, 1'b0, 1'b0);

    // SCAN_UP idle until load, then dwell 3 starting at 14
    cyc(1'b1, 1'b1, 2'b10, 4'd9, 1'b0, 8'd3, "up_idle", 1'b0, 4'd15, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b10, 4'd14, 1'b1, 8'd3, "up_load", 1'b1, 4'd14, 1'b0, 1'b1);
    up_seq = '{14, 14, 15, 15, 15, 0, 0, 0, 1};
    for (int i = 0; i < 9; i++)
      cyc(1'b1, 1'b1, 2'b10, 4'd0, 1'b0, 8'd7, "up_run", 1'b1, 4'(up_seq[i]),
          (i == 5) ? 1'b1 : 1'b0, 1'b1);

    // en low freezes mid-dwell; a load while disabled is dropped
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b0, 2'b10, 4'd7, (i == 2) ? 1'b1 : 1'b0, 8'd9, "en_low",
          1'b1, 4'd1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b10, 4'd0, 1'b0, 8'd0, "resume0", 1'b1, 4'd1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b10, 4'd0, 1'b0, 8'd0, "resume1", 1'b1, 4'd1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b10, 4'd0, 1'b0, 8'd0, "resume2", 1'b1, 4'd2, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b10, 4'd0, 1'b0, 8'd0, "resume3", 1'b1, 4'd2, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b10, 4'd0, 1'b0, 8'd0, "resume4", 1'b1, 4'd2, 1'b0, 1'b1);

    // load on a step edge; second load replaces a 15->0 wrapping step
    cyc(1'b1, 1'b1, 2'b10, 4'd15, 1'b1, 8'd1, "ld_step", 1'b1, 4'd15, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b10, 4'd0, 1'b1, 8'd1, "ld_wrap", 1'b1, 4'd0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b10, 4'd0, 1'b0, 8'd1, "ld_after", 1'b1, 4'd1, 1'b0, 1'b1);

    // SCAN_DOWN with dwell 0 behaves as dwell 1
    cyc(1'b1, 1'b1, 2'b11, 4'd1, 1'b1, 8'd0, "dn_load", 1'b1, 4'd1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b11, 4'd0, 1'b0, 8'd0, "dn_0", 1'b1, 4'd0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b11, 4'd0, 1'b0, 8'd0, "dn_15", 1'b1, 4'd15, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 2'b11, 4'd0, 1'b0, 8'd0, "dn_14", 1'b1, 4'd14, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b10, 4'd0, 1'b0, 8'd0, "dir_swap", 1'b1, 4'd15, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b10, 4'd0, 1'b0, 8'd0, "swap_wrap", 1'b1, 4'd0, 1'b1, 1'b1);

    // reset mid-scan, then SCAN stays idle without a load
    cyc(1'b0, 1'b1, 2'b10, 4'd6, 1'b1, 8'd2, "rst_run", 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b10, 4'd6, 1'b0, 8'd2, "rst_idle", 1'b0, 4'd0, 1'b0, 1'b0);

    // leave scan for DIRECT, then re-enter SCAN idle
    cyc(1'b1, 1'b1, 2'b10, 4'd3, 1'b1, 8'd4, "m_load", 1'b1, 4'd3, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b10, 4'd3, 1'b0, 8'd4, "m_hold", 1'b1, 4'd3, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 2'b01, 4'd9, 1'b0, 8'd4, "m_direct", 1'b1, 4'd9, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b10, 4'd2, 1'b0, 8'd4, "m_reenter", 1'b0, 4'd9, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b11, 4'd2, 1'b0, 8'd4, "m_idle_dn", 1'b0, 4'd9, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sel_decoder_scan.md
Name: sel_decoder_scan

Overview:
- Parametrised, registered N-to-2^N one-hot path selector.
- Next generation of the fixed 4-to-16 selector.
- Adds clocked output, enable, synchronous reset, and an auto-scan mode that steps the active path up or down with a programmable dwell time.
- Drives path-enable lines for multiplexed peripherals (LED/segment digits, sensor channels) at top level.

Parameters:
- SEL_W, 4, select width; output width OUT_W = 2**SEL_W (localparam, not overridable).
- DWELL_W, 8, width of the dwell-time counter, in clk1 cycles.

Ports:
- clk1  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  global enable; low freezes all state and outputs.
- mode  input  2  00 OFF, 01 DIRECT, 10 SCAN_UP, 11 SCAN_DOWN.
- select  input  SEL_W  DIRECT: path index; SCAN: start index captured on load.
- load  input  1  single-cycle strobe; starts or restarts a scan.
- dwell  input  DWELL_W  cycles per path in SCAN, captured on load; 0 treated as 1.
- path  output  OUT_W  registered one-hot path enable (all zero when OFF/idle).
- cur_sel  output  SEL_W  registered index of the active path.
- wrap  output  1  one-cycle pulse when the scan wraps past an end.
- busy  output  1  high while a scan is running.

Behaviour:
- Reset (rst_n low at clk1 edge): path=0, cur_sel=0, wrap=0, busy=0, dwell_cnt=0, dwell_reg=0. Reset overrides en, load and mode. Reset mid-scan aborts the scan immediately.
- en low: every register holds, wrap forced 0. load while en low is ignored, not queued.
- OFF (mode 00): path=0 and busy=0 next edge. cur_sel holds.
- DIRECT (01):
  - Each enabled edge: cur_sel<=select, path<=one-hot(select); latency 1 cycle.
  - busy=0, load ignored.
- SCAN_UP / SCAN_DOWN (1x), state machine IDLE -> RUN:
  - IDLE: path=0, busy=0.
  - load in IDLE or RUN: cur_sel<=select, path<=one-hot(select), dwell_reg<=max(dwell,1), dwell_cnt<=max(dwell,1)-1, busy<=1, state RUN.
  - RUN, dwell_cnt!=0: dwell_cnt decrements.
  - RUN, dwell_cnt==0: cur_sel steps ±1 modulo OUT_W, path follows in the same edge, dwell_cnt<=dwell_reg-1.
  - Each path is therefore held exactly dwell_reg cycles.
- wrap:
  - Pulses 1 cycle on the edge where cur_sel steps OUT_W-1 -> 0 (UP) or 0 -> OUT_W-1 (DOWN).
  - No pulse on load, even if the load index is 0 or OUT_W-1.
- Simultaneous load and step: load wins, no wrap.
- Mode switching:
  - UP <-> DOWN while RUN: direction changes at the next step; dwell_cnt is not reset.
  - Leaving SCAN for OFF/DIRECT: state -> IDLE, busy=0 next edge.
  - Re-entering SCAN: IDLE until the next load.
- Invariants:
  - path is always zero or exactly one-hot.
  - When nonzero, path == one-hot(cur_sel).
- Widths: cur_sel wraps naturally in SEL_W bits. dwell_cnt is DWELL_W bits, so no overflow path exists.

Decomposition:
- Package sel_pkg:
  - mode encodings MODE_OFF/MODE_DIRECT/MODE_SCAN_UP/MODE_SCAN_DOWN.
  - state encoding ST_IDLE/ST_RUN.
- Sub-module sel_onehot:
  - Parametrised combinational SEL_W-to-2**SEL_W decoder, output bit i = (in==i).
  - Used for both DIRECT and SCAN path generation.
- Counters and FSM stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with en=1, mode=01, select=5 -> path=0, cur_sel=0, busy=0. Release -> next edge path=16'h0020.
- DIRECT sweep (SEL_W=4): select 0..15, one per cycle -> path=1<<select one cycle later; mode=00 -> path=0 next edge.
- SCAN_UP: select=14, dwell=3, load -> path index sequence 14,14,14,15,15,15,0…; wrap high only on the 15 -> 0 edge; busy=1 throughout.
- SCAN_DOWN with dwell=0: select=1, load -> index 1,0,15,14 on consecutive cycles; wrap on the 0 -> 15 edge.
- Boundaries:
  - en low for 5 cycles mid-scan -> path/cur_sel/dwell frozen, resume exactly where stopped.
  - load coincident with step -> index = new select, no wrap.
- Reset mid-scan and mode change: rst_n=0 during RUN -> all outputs 0 next edge. Switching 10 -> 01 mid-scan -> busy=0, path=one-hot(select) next edge.
